// File: rtl/bt_uart_pkg.sv
// bt_uart_pkg: shared state encoding and framing constants for the UART transmitter
package bt_uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
  localparam int FRAME_BITS = 10;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int DEF_BIT_PERIOD = 434;
endpackage

// File: rtl/tx_shift_10bit.sv
// tx_shift_10bit: parallel-load shift-right register, refills with idle ones
module tx_shift_10bit (
  input  logic       clock,
  input  logic       reset,
  input  logic       ld,
  input  logic       en,
  input  logic [9:0] d,
  output logic       sout,
  output logic       sout_nxt
);
  logic [9:0] q;
  always_ff @(posedge clock or posedge reset)
    if (reset) q <= '1;
    else if (ld) q <= d;
    else if (en) q <= {1'b1, q[9:1]};
  assign sout = q[0];
  assign sout_nxt = q[1];
endmodule

// File: rtl/bt_uart_tx_ctrl.sv
// bt_uart_tx_ctrl: 8N1 frame sequencer pacing each bit with an external 10-bit timer
module bt_uart_tx_ctrl
  import bt_uart_pkg::*;
#(
  parameter int BIT_PERIOD = DEF_BIT_PERIOD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       uart_tx,
  output logic       timer_resetn,
  output logic       timer_active,
  output logic [9:0] timer_final_value,
  input  logic       timer_done
);
  state_t state;
  logic [3:0] bit_idx;
  logic [9:0] frame;
  logic accept, more, sout, sout_nxt;
  assign tx_ready = state == IDLE;
  assign accept = tx_ready && tx_valid;
  assign more = bit_idx < 4'(FRAME_BITS - 1);
  assign frame = {UART_IDLE_LEVEL, tx_data, 1'b0};
  // Timer sees count 0 on the first RUN cycle, so BIT_PERIOD-2 yields BIT_PERIOD-1 RUN cycles
  assign timer_final_value = 10'(BIT_PERIOD - 2);
  tx_shift_10bit u_shift (
    .clock   (clock),
    .reset   (reset),
    .ld      (accept),
    .en      (state == RUN && timer_done && more),
    .d       (frame),
    .sout    (sout),
    .sout_nxt(sout_nxt)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_idx <= '0;
      uart_tx <= UART_IDLE_LEVEL;
      tx_done <= 1'b0;
      timer_resetn <= 1'b0;
      timer_active <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: if (tx_valid) begin
          state <= LOAD;
          bit_idx <= '0;
          uart_tx <= frame[0];
        end
        LOAD: begin
          state <= RUN;
          uart_tx <= sout;
          timer_resetn <= 1'b1;
          timer_active <= 1'b1;
        end
        RUN: if (timer_done) begin
          timer_resetn <= 1'b0;
          timer_active <= 1'b0;
          if (more) begin
            state <= LOAD;
            bit_idx <= bit_idx + 4'd1;
            uart_tx <= sout_nxt;
          end else begin
            state <= IDLE;
            uart_tx <= UART_IDLE_LEVEL;
            tx_done <= bit_idx == 4'(FRAME_BITS - 1);
          end
        end
        default: begin
          state <= IDLE;
          uart_tx <= UART_IDLE_LEVEL;
          timer_resetn <= 1'b0;
          timer_active <= 1'b0;
        end
      endcase
    end
endmodule
